falu_sched: RTL
===============

# falu_sched

Round-robin scheduler that shares one combinational `falu` instance between `NREQ` requesters. Each requester presents an opcode and two IEEE-754 single-precision operands with a valid/ready handshake. The scheduler serialises the requests, registers the operands and the result around the `falu`, and returns the result, its flags and the requester ID on a single response port. It sits between the core-side request sources and the arithmetic unit.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `IDW`, `$clog2(NREQ)`: requester ID width.
- `N`, 32: operand width, passed to `falu`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester accept; at most one bit set.
- `req_op` in 3*NREQ: per-requester opcode, slice i belongs to requester i.
- `req_a` in N*NREQ: per-requester operand A.
- `req_b` in N*NREQ: per-requester operand B.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer accept.
- `rsp_id` out IDW: requester that issued the op.
- `rsp_data` out N: `falu` result.
- `rsp_ovf`, `rsp_unf` out 1 each: per-op overflow and underflow flags.
- `rsp_err` out 1: illegal opcode.
- `sticky_ovf`, `sticky_unf` out 1 each: accumulated flags.
- `clr_sticky` in 1: synchronous clear of the sticky flags.

## Operation
- FSM states are IDLE, EXEC and RESP. Reset state is IDLE.
- IDLE:
  - Round-robin pick among the set `req_valid` bits, searching from `last+1` upward with wrap.
  - `req_ready[g]` = 1 combinationally for the winner `g` only.
  - On the handshake, capture op/a/b/g into operand registers, set `last`=g, and go to EXEC.
  - With no valid requests, stay in IDLE.
- EXEC:
  - The operand registers drive `falu` (`A`, `B`, `sel`).
  - Capture the `falu` result into `rsp_data`.
  - Ops 1–4: capture `falu` overflow/underflow into `rsp_ovf`/`rsp_unf`, and OR them into the sticky flags.
  - Op 5 (compare): `rsp_ovf`=`rsp_unf`=0 and the sticky flags are unchanged, because the `falu` flags aggregate all units regardless of `sel`.
  - Ops 0, 6, 7: `rsp_err`=1, `rsp_data`=0, `rsp_ovf`=`rsp_unf`=0.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1. All `rsp_*` outputs stay stable until `rsp_valid & rsp_ready`, then go to IDLE.
  - `req_ready` = 0 in EXEC and RESP.
- Opcodes: 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 CMP.
  - The CMP result is `{29'b0, g, l, e}`.
- Sticky flags:
  - `clr_sticky` takes priority over a same-cycle set, and clears them.
  - The sticky flags are not affected by `rsp_ready`.
- `last` holds its value while no grant occurs. Reset value is NREQ-1, so requester 0 wins the first arbitration.

## Timing
- Reset values:
  - `req_ready`=0 while in reset; after reset it follows the IDLE arbitration.
  - `rsp_valid`=0.
  - `rsp_id`=0, `rsp_data`=0.
  - `rsp_ovf`=`rsp_unf`=`rsp_err`=0.
  - Sticky flags = 0.
  - `last`=NREQ-1.
- Latency:
  - The handshake occurs in cycle 0.
  - EXEC is cycle 1.
  - `rsp_valid` rises at the start of cycle 2.
- Minimum issue interval is 3 cycles (RESP→IDLE→EXEC), reached when `rsp_ready`=1 in the first RESP cycle. Throughput is therefore at most 1 op per 3 cycles.
- Fairness: with all requesters valid, the grants go 0,1,…,NREQ-1,0. A requester waits at most NREQ-1 grants.
- A requester may drop `req_valid` without a handshake. It then forfeits its turn, and arbitration re-evaluates every IDLE cycle.
- `rsp_ready` held low keeps RESP indefinitely with no new grants.
- Asserting `rst_n`=0 in any state (reset mid-operation) forces IDLE immediately. An in-flight op is discarded with no response.

## Structure
- Package `falu_pkg`:
  - opcode constants `OP_ADD`..`OP_CMP`;
  - state enum `{IDLE, EXEC, RESP}`;
  - default `N`.
- Sub-module `rr_arb #(NREQ)`:
  - inputs `req`, `last`;
  - outputs one-hot `gnt` and binary `gnt_id`;
  - purely combinational.
- One `falu` instance is driven only from the operand registers.
- FSM, operand registers, response registers and sticky flags live in `falu_sched`.

## Test plan
- Req 0 ADD 0x3F800000 + 0x40000000, `rsp_ready`=1 → `rsp_valid` in cycle 2, `rsp_data`=0x40400000, `rsp_id`=0, flags 0.
- Req 2 MUL 0x40000000 × 0x40400000 → `rsp_data`=0x40C00000, `rsp_id`=2. Req 1 CMP 0x40000000 vs 0x3F800000 → `rsp_data`=0x00000004, `rsp_ovf`=`rsp_unf`=0.
- All 4 requesters valid continuously after reset → grant order 0,1,2,3,0, each accepted exactly once per 12 cycles, one `req_ready` bit at a time.
- ADD with A=0x7F800000 → `rsp_data`=0, `rsp_ovf`=1, `sticky_ovf`=1. The sticky flag persists through a following clean op and clears one cycle after the `clr_sticky` pulse.
- Op 6 → `rsp_err`=1, `rsp_data`=0. `rsp_ready` low for 5 cycles → `rsp_*` stable, `req_ready`=0, no grant until the response is accepted.
- `rst_n` low during EXEC → next cycle `rsp_valid`=0 and state IDLE, with no response ever issued for that op. The first grant after reset goes to requester 0.

Source files
------------

// File: rtl/falu_pkg.sv
// Shared opcodes, scheduler states, default operand width and the float packing helper.
package falu_pkg;

    localparam int FALU_N = 32;

    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4;
    localparam logic [2:0] OP_CMP = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Returns {ovf, unf, word}; out-of-range exponents collapse the word to zero.
    function automatic logic [33:0] fp_pack(input logic s, input logic signed [10:0] e,
                                            input logic [22:0] f, input logic z);
        logic [33:0] r;
        r = '0;
        if (z)
            r = '0;
        else if (e >= 11'sd255)
            r[33] = 1'b1;
        else if (e <= 11'sd0)
            r[32] = 1'b1;
        else
            r[31:0] = {s, e[7:0], f};
        return r;
    endfunction

endpackage

// File: rtl/falu.sv
// Single-precision ADD/SUB/MUL/DIV/CMP; denormals flush to zero, results truncate.
// Latency: 0, purely combinational.
// Backpressure: none; overflow/underflow are ORed across every unit regardless of sel.
module falu import falu_pkg::*; #(
    parameter int N = FALU_N
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   sel,
    output logic [N-1:0] R,
    output logic         overflow,
    output logic         underflow
);

    function automatic logic signed [10:0] sx(input logic [7:0] e);
        return $signed({3'b000, e});
    endfunction

    function automatic logic [33:0] fp_addsub(input logic sa, input logic [7:0] ea, input logic [23:0] ma,
                                              input logic sb, input logic [7:0] eb, input logic [23:0] mb);
        logic               a_big, s, z;
        logic [7:0]         eg, d;
        logic [23:0]        mg, ms, diff;
        logic [24:0]        sum;
        logic [22:0]        f;
        logic [4:0]         lead, sh;
        logic signed [10:0] e;
        a_big = {ea, ma} >= {eb, mb};
        s     = a_big ? sa : sb;
        eg    = a_big ? ea : eb;
        mg    = a_big ? ma : mb;
        d     = a_big ? ea - eb : eb - ea;
        ms    = (a_big ? mb : ma) >> d;
        sum   = '0;
        diff  = '0;
        lead  = '0;
        sh    = '0;
        if (sa == sb) begin
            sum = {1'b0, mg} + {1'b0, ms};
            z   = (sum == '0);
            f   = sum[24] ? sum[23:1] : sum[22:0];
            e   = sx(eg) + (sum[24] ? 11'sd1 : 11'sd0);
        end else begin
            diff = mg - ms;
            z    = (diff == '0);
            for (int i = 0; i < 24; i++)
                if (diff[i]) lead = 5'(i);
            sh = 5'd23 - lead;
            f  = 23'(diff << sh);
            e  = sx(eg) - $signed({6'b0, sh});
        end
        return fp_pack(s, e, f, z);
    endfunction

    function automatic logic [33:0] fp_mul(input logic s, input logic [7:0] ea, input logic [23:0] ma,
                                           input logic [7:0] eb, input logic [23:0] mb);
        logic [24:0]        ph;
        logic [22:0]        f;
        logic signed [10:0] e;
        ph = 25'(({24'b0, ma} * {24'b0, mb}) >> 23);
        f  = ph[24] ? ph[23:1] : ph[22:0];
        e  = sx(ea) + sx(eb) - 11'sd127 + (ph[24] ? 11'sd1 : 11'sd0);
        return fp_pack(s, e, f, (ma == '0) || (mb == '0));
    endfunction

    function automatic logic [33:0] fp_div(input logic s, input logic [7:0] ea, input logic [23:0] ma,
                                           input logic [7:0] eb, input logic [23:0] mb);
        logic [23:0]        mbz;
        logic [24:0]        q;
        logic [22:0]        f;
        logic signed [10:0] e;
        // Divide-by-zero yields a zero word with no flag; the divisor is forced non-zero.
        mbz = (mb == '0) ? 24'd1 : mb;
        q   = 25'({ma, 24'b0} / {24'b0, mbz});
        f   = q[24] ? q[23:1] : q[22:0];
        e   = sx(ea) - sx(eb) + (q[24] ? 11'sd127 : 11'sd126);
        return fp_pack(s, e, f, (ma == '0) || (mb == '0));
    endfunction

    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        inf_in, cmp_eq, cmp_gt, cmp_lt;
    logic [33:0] r_add, r_sub, r_mul, r_div;

    assign ea     = A[30:23];
    assign eb     = B[30:23];
    assign ma     = (ea == 8'd0) ? 24'd0 : {1'b1, A[22:0]};
    assign mb     = (eb == 8'd0) ? 24'd0 : {1'b1, B[22:0]};
    assign inf_in = (ea == 8'hFF) || (eb == 8'hFF);

    assign r_add = fp_addsub(A[31], ea, ma,  B[31], eb, mb);
    assign r_sub = fp_addsub(A[31], ea, ma, ~B[31], eb, mb);
    assign r_mul = fp_mul(A[31] ^ B[31], ea, ma, eb, mb);
    assign r_div = fp_div(A[31] ^ B[31], ea, ma, eb, mb);

    assign overflow  = inf_in | r_add[33] | r_sub[33] | r_mul[33] | r_div[33];
    assign underflow = r_add[32] | r_sub[32] | r_mul[32] | r_div[32];

    always_comb begin
        cmp_eq = (A == B) || ((ea == 8'd0) && (eb == 8'd0));
        cmp_gt = 1'b0;
        if (!cmp_eq) begin
            if (A[31] != B[31])
                cmp_gt = ~A[31];
            else if (!A[31])
                cmp_gt = A[30:0] > B[30:0];
            else
                cmp_gt = A[30:0] < B[30:0];
        end
        cmp_lt = ~cmp_eq & ~cmp_gt;

        R = '0;
        case (sel)
            OP_ADD:  R = inf_in ? '0 : r_add[31:0];
            OP_SUB:  R = inf_in ? '0 : r_sub[31:0];
            OP_MUL:  R = inf_in ? '0 : r_mul[31:0];
            OP_DIV:  R = inf_in ? '0 : r_div[31:0];
            OP_CMP:  R[2:0] = {cmp_gt, cmp_lt, cmp_eq};
            default: R = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: searches req from last+1 upward with wrap, one-hot grant plus index.
// Latency: 0, purely combinational.
// Backpressure: none; caller qualifies the grant with its own state.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IDW'((int'(last) + i) % NREQ);
            if (gnt == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/falu_sched.sv
// Round-robin scheduler sharing one falu between NREQ requesters with a registered response port.
// Latency: handshake cycle 0, execute cycle 1, rsp_valid from cycle 2; one op per 3 cycles at best.
// Backpressure: rsp_ready low holds RESP with all rsp_* stable and req_ready low for every requester.
module falu_sched import falu_pkg::*; #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int N    = FALU_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_op,
    input  logic [N*NREQ-1:0] req_a,
    input  logic [N*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_data,
    output logic              rsp_ovf,
    output logic              rsp_unf,
    output logic              rsp_err,
    output logic              sticky_ovf,
    output logic              sticky_unf,
    input  logic              clr_sticky
);

    state_e         state_q, state_d;
    logic [IDW-1:0] last_q, id_q, rsp_id_q;
    logic [2:0]     op_q;
    logic [N-1:0]   a_q, b_q, rsp_data_q;
    logic           rsp_ovf_q, rsp_unf_q, rsp_err_q;
    logic           sticky_ovf_q, sticky_unf_q;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            take;
    logic [2:0]      pick_op;
    logic [N-1:0]    pick_a, pick_b, falu_r;
    logic            falu_ovf, falu_unf, arith;

    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (req_valid),
        .last   (last_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    falu #(.N(N)) u_falu (
        .A         (a_q),
        .B         (b_q),
        .sel       (op_q),
        .R         (falu_r),
        .overflow  (falu_ovf),
        .underflow (falu_unf)
    );

    // The reset term keeps req_ready low while rst_n is held, even though the state already reads IDLE.
    assign req_ready = (rst_n && state_q == IDLE) ? gnt : '0;
    assign take      = (state_q == IDLE) && (gnt != '0);
    assign arith     = (op_q >= OP_ADD) && (op_q <= OP_DIV);

    always_comb begin
        pick_op = '0;
        pick_a  = '0;
        pick_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                pick_op = req_op[3*i +: 3];
                pick_a  = req_a[N*i +: N];
                pick_b  = req_b[N*i +: N];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= IDW'(NREQ - 1);
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_unf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                op_q   <= pick_op;
                a_q    <= pick_a;
                b_q    <= pick_b;
                id_q   <= gnt_id;
                last_q <= gnt_id;
            end
            if (state_q == EXEC) begin
                rsp_id_q   <= id_q;
                rsp_data_q <= '0;
                rsp_ovf_q  <= 1'b0;
                rsp_unf_q  <= 1'b0;
                rsp_err_q  <= 1'b0;
                // CMP drops the flags: falu reports them from every unit, not just the selected one.
                case (op_q)
                    OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                        rsp_data_q <= falu_r;
                        rsp_ovf_q  <= falu_ovf;
                        rsp_unf_q  <= falu_unf;
                    end
                    OP_CMP:  rsp_data_q <= falu_r;
                    default: rsp_err_q  <= 1'b1;
                endcase
            end
            if (clr_sticky) begin
                sticky_ovf_q <= 1'b0;
                sticky_unf_q <= 1'b0;
            end else if (state_q == EXEC && arith) begin
                sticky_ovf_q <= sticky_ovf_q | falu_ovf;
                sticky_unf_q <= sticky_unf_q | falu_unf;
            end
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_unf    = rsp_unf_q;
    assign rsp_err    = rsp_err_q;
    assign sticky_ovf = sticky_ovf_q;
    assign sticky_unf = sticky_unf_q;

endmodule
